// File: rtl/encoder_8to3_serial_pkg.sv
// Shared sizing and state encoding for the serial 8-to-3 encoder.
package enc_pkg;

    localparam int unsigned N = 8;
    localparam int unsigned W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE,
        EMIT
    } state_e;

endpackage

// File: rtl/encoder_8to3_serial_if.sv
// Input-vector and output-index handshakes of the serial 8-to-3 encoder.
interface encoder_8to3_serial_if;
    import enc_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sel;
    logic         last;
    logic         zero_seen;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sel,
        input  last,
        input  zero_seen
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sel,
        output last,
        output zero_seen
    );

endinterface

// File: rtl/encoder_8to3_serial_prio_enc8.sv
// Lowest-set-bit priority encoder with an exactly-one-bit-set flag.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         onehot
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx = W'(i);
            end
        end
        onehot = (in != '0) && ((in & (in - N'(1))) == '0);
    end

endmodule

// File: rtl/encoder_8to3_serial.sv
// Turns an accepted bitmap into a stream of set-bit indices, lowest first.
module encoder_8to3_serial
    import enc_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    encoder_8to3_serial_if.slave bus
);

    state_e       state_q;
    logic [N-1:0] pending_q;
    logic         zero_seen_q;

    logic [W-1:0] idx;
    logic         onehot;
    logic         out_valid;
    logic         last;
    logic         in_ready;
    logic         accept;
    logic         out_fire;
    logic [N-1:0] clear_mask;

    prio_enc8 u_prio (
        .in     (pending_q),
        .idx    (idx),
        .onehot (onehot)
    );

    always_comb begin
        out_valid  = rst_n && (state_q == EMIT);
        last       = out_valid && onehot;
        out_fire   = out_valid && bus.out_ready;
        // A final beat frees the slot in the same cycle, so vectors stream without a bubble.
        in_ready   = rst_n && ((state_q == IDLE) || (out_fire && last));
        accept     = bus.in_valid && in_ready;
        clear_mask = N'(1) << idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            zero_seen_q <= 1'b0;
            if (accept) begin
                pending_q   <= bus.in_vec;
                state_q     <= (bus.in_vec != '0) ? EMIT : IDLE;
                zero_seen_q <= (bus.in_vec == '0);
            end else if (out_fire) begin
                pending_q <= pending_q & ~clear_mask;
                state_q   <= last ? IDLE : EMIT;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sel       = out_valid ? idx : '0;
    assign bus.last      = last;
    assign bus.zero_seen = zero_seen_q;

endmodule

// File: tb/tb_encoder_8to3_serial.sv
// Directed and random checks of the serial 8-to-3 encoder.
module tb_encoder_8to3_serial;
    import enc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    encoder_8to3_serial_if bus ();

    encoder_8to3_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, let combinational outputs settle before sampling.
    task automatic drive(input logic iv, input logic [7:0] vec, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_vec    = vec;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] s, input logic l);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
        chk({tag, "_last"}, 32'(bus.last), 32'(l));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] acc;
        int         beats;
        int         prev;
        int         cyc;
        logic       done;
        logic       order_ok;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;

        // Reset
        drive(1'b1, 8'hff, 1'b1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_last", 32'(bus.last), 32'd0);
        chk("rst_zero_seen", 32'(bus.zero_seen), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: 1010_0100 with out_ready high
        drive(1'b1, 8'b1010_0100, 1'b1);
        chk("t1_accept", 32'(bus.in_ready), 32'd1);
        chk("t1_no_comb", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t1_b0", 3'd2, 1'b0);
        chk("t1_b0_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t1_b1", 3'd5, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t1_b2", 3'd7, 1'b1);
        chk("t1_b2_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t1_done", 32'(bus.out_valid), 32'd0);
        chk("t1_done_sel", 32'(bus.sel), 32'd0);

        // 2: 0001_0010 with backpressure
        drive(1'b1, 8'b0001_0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            chk_beat("t2_hold", 3'd1, 1'b0);
            chk("t2_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t2_b0", 3'd1, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t2_b1", 3'd4, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t2_done", 32'(bus.out_valid), 32'd0);

        // 3: all-zero vector
        drive(1'b1, 8'h00, 1'b1);
        chk("t3_accept", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t3_zero_seen", 32'(bus.zero_seen), 32'd1);
        chk("t3_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t3_zero_pulse", 32'(bus.zero_seen), 32'd0);

        // 4: FF then 01 offered on the final beat
        drive(1'b1, 8'hff, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk_beat("t4_ff", 3'(i), 1'b0);
        end
        drive(1'b1, 8'h01, 1'b1);
        chk_beat("t4_ff7", 3'd7, 1'b1);
        chk("t4_b2b_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t4_01", 3'd0, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t4_done", 32'(bus.out_valid), 32'd0);

        // 5: reset mid-stream after the sel=4 beat
        drive(1'b1, 8'hf0, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_beat("t5_b0", 3'd4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_rst_sel", 32'(bus.sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("t5_no_beats", 32'(bus.out_valid), 32'd0);
        end

        // 6: random vectors, random out_ready, decoded beats must rebuild the vector
        for (int n = 0; n < 200; n++) begin
            v = 8'($urandom_range(0, 255));
            if (n == 0) v = 8'h00;
            if (n == 1) v = 8'h80;
            drive(1'b1, v, 1'($urandom_range(0, 1)));
            chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
            acc      = '0;
            beats    = 0;
            prev     = -1;
            order_ok = 1'b1;
            done     = (v == 8'h00);
            cyc      = 0;
            while (!done && cyc < 60) begin
                drive(1'b0, 8'h00, 1'($urandom_range(0, 1)));
                cyc++;
                if (bus.out_valid && bus.out_ready) begin
                    acc = acc | (8'h01 << bus.sel);
                    beats++;
                    if (int'(bus.sel) <= prev) order_ok = 1'b0;
                    prev = int'(bus.sel);
                    if (bus.last) done = 1'b1;
                end
            end
            if (v == 8'h00) begin
                drive(1'b0, 8'h00, 1'b1);
                chk("t6_zero_seen", 32'(bus.zero_seen), 32'd1);
            end
            chk("t6_timeout", 32'(done), 32'd1);
            chk("t6_or_decoded", 32'(acc), 32'(v));
            chk("t6_beats", 32'(beats), 32'($countones(v)));
            chk("t6_order", 32'(order_ok), 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1);
        chk("t6_idle", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
